// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control FSM: states, opcodes and
// the select codes it drives into the datapath.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] IMM_NONE = 2'd0;
    localparam logic [1:0] IMM_I    = 2'd1;
    localparam logic [1:0] IMM_S    = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic PC_SRC_PC4  = 1'b0;
    localparam logic PC_SRC_JALR = 1'b1;

    typedef struct packed {
        logic is_opimm;
        logic is_op;
        logic is_load;
        logic is_store;
        logic is_jalr;
        logic legal;
    } opc_class_t;

    function automatic logic [1:0] imm_sel_of(input opc_class_t c);
        if (c.is_store)
            return IMM_S;
        else if (c.is_opimm || c.is_load || c.is_jalr)
            return IMM_I;
        else
            return IMM_NONE;
    endfunction

    function automatic logic [1:0] wb_sel_of(input opc_class_t c);
        if (c.is_load)
            return WB_MEM;
        else if (c.is_jalr)
            return WB_PC4;
        else
            return WB_ALU;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_opcode_decode.sv
// Opcode classifier, shared between the control FSM and the datapath's
// immediate select.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_opimm,
    output logic       is_op,
    output logic       is_load,
    output logic       is_store,
    output logic       is_jalr,
    output logic       legal
);

    assign is_opimm = (opcode == OPC_OP_IMM);
    assign is_op    = (opcode == OPC_OP);
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign is_jalr  = (opcode == OPC_JALR);
    assign legal    = is_opimm | is_op | is_load | is_store | is_jalr;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM over a shared req/ready memory port.
// Optional retired-instruction counter enabled by defining MC_CTRL_INSTRET_EN.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR on mem_ready
// DECODE | classify opcode, trap on unsupported
// EXEC   | ALU operation (immediate or rs2 operand)
// MEM    | load/store data access at ALU address; store retires here
// WB     | register write-back and PC update, retire
// TRAP   | sticky illegal, idle until reset
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_rdata_vld,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_ld,
    output logic        pc_we,
    output logic        pc_src,
    output logic        alu_src_b,
    output logic [1:0]  imm_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t          state;
    state_t          state_next;
    opc_class_t      dec;
    logic [TO_W-1:0] to_cnt;
    logic            req_phase;
    logic            to_expire;
    logic            retire;
    logic            rd_nonzero;

    mc_opcode_decode u_opcode_decode (
        .opcode   (instr[6:0]),
        .is_opimm (dec.is_opimm),
        .is_op    (dec.is_op),
        .is_load  (dec.is_load),
        .is_store (dec.is_store),
        .is_jalr  (dec.is_jalr),
        .legal    (dec.legal)
    );

    assign req_phase  = (state == ST_FETCH) || (state == ST_MEM);
    assign to_expire  = req_phase && !mem_ready && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
    assign rd_nonzero = (instr[11:7] != 5'd0);
    assign retire     = !rst && ((state == ST_WB) ||
                                 (state == ST_MEM && mem_ready && dec.is_store));

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (mem_ready)
                    state_next = ST_DECODE;
                else if (to_expire)
                    state_next = ST_TRAP;
            end
            ST_DECODE: state_next = dec.legal ? ST_EXEC : ST_TRAP;
            ST_EXEC:   state_next = (dec.is_load || dec.is_store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (mem_ready)
                    state_next = dec.is_store ? ST_FETCH : ST_WB;
                else if (to_expire)
                    state_next = ST_TRAP;
            end
            ST_WB:   state_next = ST_FETCH;
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_FETCH;
        endcase
    end

    // Reset gates every combinational output so an in-flight request drops
    // in the same cycle rst is seen.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_ld     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_PC4;
        alu_src_b = 1'b0;
        imm_sel   = IMM_NONE;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_ld   = mem_ready;
                end
                ST_DECODE: imm_sel = imm_sel_of(dec);
                ST_EXEC: begin
                    imm_sel   = imm_sel_of(dec);
                    alu_src_b = !dec.is_op;
                end
                ST_MEM: begin
                    imm_sel  = imm_sel_of(dec);
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = dec.is_store;
                    pc_we    = mem_ready && dec.is_store;
                end
                ST_WB: begin
                    imm_sel = imm_sel_of(dec);
                    reg_we  = rd_nonzero;
                    wb_sel  = wb_sel_of(dec);
                    pc_we   = 1'b1;
                    pc_src  = dec.is_jalr ? PC_SRC_JALR : PC_SRC_PC4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= '0;
        else if (mem_ready || !req_phase || (state_next != state))
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            illegal <= 1'b0;
        else if (state_next == ST_TRAP)
            illegal <= 1'b1;
    end

`ifdef MC_CTRL_INSTRET_EN
    always_ff @(posedge clk) begin
        if (rst)
            instret <= 32'h0;
        else if (retire)
            instret <= instret + 32'd1;
    end

    logic unused_sink;
    assign unused_sink = ^{mem_rdata_vld, instr[31:12]};
`else
    assign instret = 32'h0;

    logic unused_sink;
    assign unused_sink = ^{mem_rdata_vld, instr[31:12], retire};
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: instruction sequences, wait states,
// timeout boundary, illegal-opcode trap and mid-instruction reset.
module tb_mc_ctrl_fsm;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SW   = 32'h0020_A423;
    localparam logic [31:0] I_LW   = 32'h0000_A183;
    localparam logic [31:0] I_JALR = 32'h0001_8067;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;

`ifdef MC_CTRL_INSTRET_EN
    localparam logic [31:0] IE = 32'd1;
`else
    localparam logic [31:0] IE = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_rdata_vld;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_ld, pc_we, pc_src, alu_src_b;
    logic [1:0]  imm_sel, wb_sel;
    logic        reg_we, illegal;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_TIMEOUT(16), .TO_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .mem_rdata_vld (mem_rdata_vld),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .addr_sel      (addr_sel),
        .ir_ld         (ir_ld),
        .pc_we         (pc_we),
        .pc_src        (pc_src),
        .alu_src_b     (alu_src_b),
        .imm_sel       (imm_sel),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .illegal       (illegal),
        .instret       (instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs on the falling edge, settle, then caller checks.
    task automatic drive(input logic rdy, input logic [31:0] ins, input logic r);
        @(negedge clk);
        mem_ready = rdy;
        instr     = ins;
        rst       = r;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        instr         = 32'h0;
        mem_rdata_vld = 1'b0;
        mem_ready     = 1'b0;

        drive(0, 32'h0, 1);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_illegal", {31'h0, illegal}, 32'h0);
        chk("rst_instret", instret, 32'h0);

        // ADDI x1,x0,5 with zero-wait memory
        drive(1, I_ADDI, 0);
        chk("addi_f_req", {31'h0, mem_req}, 32'h1);
        chk("addi_f_irld", {31'h0, ir_ld}, 32'h1);
        chk("addi_f_asel", {31'h0, addr_sel}, 32'h0);
        chk("addi_f_we", {31'h0, mem_we}, 32'h0);
        drive(1, I_ADDI, 0);
        chk("addi_d_imm", {30'h0, imm_sel}, 32'h1);
        chk("addi_d_req", {31'h0, mem_req}, 32'h0);
        drive(1, I_ADDI, 0);
        chk("addi_e_srcb", {31'h0, alu_src_b}, 32'h1);
        chk("addi_e_imm", {30'h0, imm_sel}, 32'h1);
        drive(1, I_ADDI, 0);
        chk("addi_w_regwe", {31'h0, reg_we}, 32'h1);
        chk("addi_w_wbsel", {30'h0, wb_sel}, 32'h0);
        chk("addi_w_pcwe", {31'h0, pc_we}, 32'h1);
        chk("addi_w_pcsrc", {31'h0, pc_src}, 32'h0);

        // SW x2,8(x1) with three wait states in MEM
        drive(1, I_SW, 0);
        chk("sw_f_req", {31'h0, mem_req}, 32'h1);
        chk("sw_f_irld", {31'h0, ir_ld}, 32'h1);
        chk("addi_instret", instret, IE * 32'd1);
        drive(1, I_SW, 0);
        chk("sw_d_imm", {30'h0, imm_sel}, 32'h2);
        drive(0, I_SW, 0);
        chk("sw_e_srcb", {31'h0, alu_src_b}, 32'h1);
        chk("sw_e_imm", {30'h0, imm_sel}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            drive(0, I_SW, 0);
            chk("sw_m_wait_req", {31'h0, mem_req}, 32'h1);
            chk("sw_m_wait_we", {31'h0, mem_we}, 32'h1);
            chk("sw_m_wait_asel", {31'h0, addr_sel}, 32'h1);
            chk("sw_m_wait_pcwe", {31'h0, pc_we}, 32'h0);
            chk("sw_m_wait_regwe", {31'h0, reg_we}, 32'h0);
        end
        drive(1, I_SW, 0);
        chk("sw_m_rdy_req", {31'h0, mem_req}, 32'h1);
        chk("sw_m_rdy_we", {31'h0, mem_we}, 32'h1);
        chk("sw_m_rdy_pcwe", {31'h0, pc_we}, 32'h1);
        chk("sw_m_rdy_pcsrc", {31'h0, pc_src}, 32'h0);
        chk("sw_m_rdy_regwe", {31'h0, reg_we}, 32'h0);

        // LW x3,0(x1)
        drive(1, I_LW, 0);
        chk("lw_f_asel", {31'h0, addr_sel}, 32'h0);
        chk("lw_f_we", {31'h0, mem_we}, 32'h0);
        chk("sw_instret", instret, IE * 32'd2);
        drive(1, I_LW, 0);
        chk("lw_d_imm", {30'h0, imm_sel}, 32'h1);
        drive(1, I_LW, 0);
        chk("lw_e_srcb", {31'h0, alu_src_b}, 32'h1);
        drive(1, I_LW, 0);
        chk("lw_m_req", {31'h0, mem_req}, 32'h1);
        chk("lw_m_asel", {31'h0, addr_sel}, 32'h1);
        chk("lw_m_we", {31'h0, mem_we}, 32'h0);
        chk("lw_m_pcwe", {31'h0, pc_we}, 32'h0);
        drive(1, I_LW, 0);
        chk("lw_w_wbsel", {30'h0, wb_sel}, 32'h1);
        chk("lw_w_regwe", {31'h0, reg_we}, 32'h1);
        chk("lw_w_pcwe", {31'h0, pc_we}, 32'h1);

        // JALR x0,0(x3)
        drive(1, I_JALR, 0);
        chk("jalr_f_irld", {31'h0, ir_ld}, 32'h1);
        chk("lw_instret", instret, IE * 32'd3);
        drive(1, I_JALR, 0);
        chk("jalr_d_imm", {30'h0, imm_sel}, 32'h1);
        drive(1, I_JALR, 0);
        chk("jalr_e_srcb", {31'h0, alu_src_b}, 32'h1);
        drive(1, I_JALR, 0);
        chk("jalr_w_regwe", {31'h0, reg_we}, 32'h0);
        chk("jalr_w_pcsrc", {31'h0, pc_src}, 32'h1);
        chk("jalr_w_wbsel", {30'h0, wb_sel}, 32'h2);
        chk("jalr_w_pcwe", {31'h0, pc_we}, 32'h1);

        // LW abandoned by reset in MEM
        drive(1, I_LW, 0);
        chk("jalr_instret", instret, IE * 32'd4);
        drive(1, I_LW, 0);
        drive(1, I_LW, 0);
        drive(0, I_LW, 1);
        chk("rstmem_req", {31'h0, mem_req}, 32'h0);
        chk("rstmem_pcwe", {31'h0, pc_we}, 32'h0);

        // Back in FETCH; ready arrives on the last allowed cycle
        for (int i = 1; i <= 15; i++) begin
            drive(0, I_ADDI, 0);
            chk("to_ok_req", {31'h0, mem_req}, 32'h1);
            chk("to_ok_asel", {31'h0, addr_sel}, 32'h0);
            chk("to_ok_illegal", {31'h0, illegal}, 32'h0);
        end
        chk("rstmem_instret", instret, 32'h0);
        drive(1, I_ADDI, 0);
        chk("to_ok_irld", {31'h0, ir_ld}, 32'h1);
        drive(0, I_ADDI, 0);
        chk("to_ok_decode_imm", {30'h0, imm_sel}, 32'h1);
        chk("to_ok_decode_req", {31'h0, mem_req}, 32'h0);
        chk("to_ok_decode_ill", {31'h0, illegal}, 32'h0);
        drive(0, I_ADDI, 0);
        chk("to_ok_exec_srcb", {31'h0, alu_src_b}, 32'h1);
        drive(0, I_ADDI, 0);
        chk("to_ok_wb_pcwe", {31'h0, pc_we}, 32'h1);

        // FETCH never answered: trap on cycle 17
        for (int i = 1; i <= 16; i++) begin
            drive(0, I_ADDI, 0);
            chk("to_wait_req", {31'h0, mem_req}, 32'h1);
            chk("to_wait_illegal", {31'h0, illegal}, 32'h0);
        end
        chk("to_ok_instret", instret, IE * 32'd1);
        drive(1, I_ADDI, 0);
        chk("to_trap_illegal", {31'h0, illegal}, 32'h1);
        chk("to_trap_req", {31'h0, mem_req}, 32'h0);
        chk("to_trap_irld", {31'h0, ir_ld}, 32'h0);

        drive(1, I_JAL, 1);
        chk("to_rst_req", {31'h0, mem_req}, 32'h0);

        // JAL is unsupported: trap after DECODE, sticky until reset
        drive(1, I_JAL, 0);
        chk("jal_f_req", {31'h0, mem_req}, 32'h1);
        chk("jal_f_irld", {31'h0, ir_ld}, 32'h1);
        chk("jal_f_illegal", {31'h0, illegal}, 32'h0);
        drive(1, I_JAL, 0);
        chk("jal_d_imm", {30'h0, imm_sel}, 32'h0);
        chk("jal_d_illegal", {31'h0, illegal}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            drive(1, I_JAL, 0);
            chk("jal_trap_illegal", {31'h0, illegal}, 32'h1);
            chk("jal_trap_req", {31'h0, mem_req}, 32'h0);
            chk("jal_trap_irld", {31'h0, ir_ld}, 32'h0);
            chk("jal_trap_pcwe", {31'h0, pc_we}, 32'h0);
            chk("jal_trap_regwe", {31'h0, reg_we}, 32'h0);
        end
        drive(1, I_ADDI, 1);
        drive(1, I_ADDI, 0);
        chk("resume_illegal", {31'h0, illegal}, 32'h0);
        chk("resume_req", {31'h0, mem_req}, 32'h1);
        chk("resume_irld", {31'h0, ir_ld}, 32'h1);
        drive(1, I_ADDI, 0);
        chk("resume_decode_imm", {30'h0, imm_sel}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
